// File: rtl/spi_pkg.sv
// Shared SPI types: mode bundle, synchroniser depth
// and the transmitter state encoding.
package spi_pkg;

  localparam int SPI_SYNC_STAGES = 2;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_tx_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO, power-of-two depth, registered occupancy.
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i,
// pop_i/data_o (head, show-ahead), full_o, empty_o, level_o.
module fifo_sync #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [LW-1:0]     r_cnt;
  logic              w_push;
  logic              w_pop;

  assign full_o  = (r_cnt == LW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rp];
  assign level_o = r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + LW'(1);
        2'b01:   r_cnt <= r_cnt - LW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= data_i;
  end

endmodule

// File: rtl/spi_periph_tx.sv
// SPI peripheral transmitter: oversampled SCK/CSn, TX FIFO, all modes.
// Ports: clk_i, rst_i, spi_sck_i, spi_csn_i, spi_sd_o, spi_oe_o,
// tx_data_i/tx_valid_i/tx_ready_o, underrun_o, level_o.
module spi_periph_tx
  import spi_pkg::*;
#(
  parameter int              DATA_W     = 8,
  parameter int              FIFO_DEPTH = 4,
  parameter bit              CPOL       = 1'b0,
  parameter bit              CPHA       = 1'b0,
  parameter bit              MSB_FIRST  = 1'b1,
  parameter logic [DATA_W-1:0] FILL     = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          spi_sck_i,
  input  logic                          spi_csn_i,
  output logic                          spi_sd_o,
  output logic                          spi_oe_o,
  input  logic [DATA_W-1:0]             tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam spi_mode_t MODE = '{cpol: CPOL, cpha: CPHA};
  localparam int        CW   = $clog2(DATA_W);

  logic [SPI_SYNC_STAGES-1:0] r_sck_sync;
  logic [SPI_SYNC_STAGES-1:0] r_csn_sync;
  logic                       r_sck_d;
  logic                       r_csn_d;

  spi_tx_state_e r_state;
  spi_tx_state_e w_state_nx;

  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_pend;
  logic              r_sd;
  logic              r_underrun;

  logic w_sck_s, w_csn_s;
  logic w_lead, w_trail;
  logic w_sample, w_launch;
  logic w_csn_fall, w_csn_rise;
  logic w_active, w_load;
  logic w_full, w_empty;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_word_sh;
  logic [DATA_W-1:0] w_shift_sh;
  logic              w_word_bit;
  logic              w_shift_bit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sck_sync <= {SPI_SYNC_STAGES{MODE.cpol}};
      r_csn_sync <= {SPI_SYNC_STAGES{1'b1}};
      r_sck_d    <= MODE.cpol;
      r_csn_d    <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SPI_SYNC_STAGES-2:0], spi_sck_i};
      r_csn_sync <= {r_csn_sync[SPI_SYNC_STAGES-2:0], spi_csn_i};
      r_sck_d    <= w_sck_s;
      r_csn_d    <= w_csn_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SPI_SYNC_STAGES-1];
  assign w_csn_s    = r_csn_sync[SPI_SYNC_STAGES-1];
  assign w_lead     = (w_sck_s != MODE.cpol) & (r_sck_d == MODE.cpol);
  assign w_trail    = (w_sck_s == MODE.cpol) & (r_sck_d != MODE.cpol);
  assign w_sample   = MODE.cpha ? w_trail : w_lead;
  assign w_launch   = MODE.cpha ? w_lead : w_trail;
  assign w_csn_fall = ~w_csn_s & r_csn_d;
  assign w_csn_rise = w_csn_s & ~r_csn_d;

  // SCK edges count only while selected and shifting.
  assign w_active = (r_state == SHIFT) & ~w_csn_s;

  // A pending reload always lands on a launch edge:
  // trailing for CPHA=0, leading for CPHA=1.
  assign w_load = ((r_state == LOAD) & ~w_csn_rise)
                | (w_active & r_pend & w_launch);

  fifo_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_valid_i),
    .data_i  (tx_data_i),
    .pop_i   (w_load),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  assign w_word      = w_empty ? FILL : w_head;
  assign w_word_bit  = MSB_FIRST ? w_word[DATA_W-1] : w_word[0];
  assign w_word_sh   = MSB_FIRST ? (w_word << 1) : (w_word >> 1);
  assign w_shift_bit = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
  assign w_shift_sh  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_csn_fall) w_state_nx = LOAD;
      LOAD:    w_state_nx = SHIFT;
      SHIFT:   w_state_nx = SHIFT;
      default: w_state_nx = IDLE;
    endcase
    if (w_csn_rise) w_state_nx = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load & w_empty;
      if (w_csn_rise) begin
        r_cnt  <= '0;
        r_pend <= 1'b0;
      end else begin
        if (w_load) begin
          r_pend <= 1'b0;
          if (r_state == LOAD) r_cnt <= '0;
          // CPHA=1 frame start: hold the line until the first launch.
          if ((r_state == LOAD) && MODE.cpha) begin
            r_shift <= w_word;
          end else begin
            r_shift <= w_word_sh;
            r_sd    <= w_word_bit;
          end
        end else if (w_active & w_launch) begin
          r_shift <= w_shift_sh;
          r_sd    <= w_shift_bit;
        end
        if (w_active & w_sample) begin
          if (r_cnt == CW'(DATA_W - 1)) begin
            r_cnt  <= '0;
            r_pend <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end
  end

  assign spi_sd_o   = r_sd;
  assign spi_oe_o   = (r_state != IDLE);
  assign tx_ready_o = ~w_full;
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_spi_periph_tx.sv
// Bench for spi_periph_tx: five instances (modes 0-3, LSB-first,
// 12-bit) share one SPI controller and one push port.
module tb_spi_periph_tx;

  localparam int N     = 5;
  localparam int DEPTH = 4;

  // bit i describes instance i; instance 4 is the 12-bit one
  localparam logic [N-1:0] P_CPOL = 5'b01100;
  localparam logic [N-1:0] P_CPHA = 5'b01010;
  localparam logic [N-1:0] P_MSB  = 5'b10111;
  localparam logic [31:0]  P_FILL = {8'hE1, 8'h69, 8'h96, 8'h00};

  logic         clk = 1'b0;
  logic         rst;
  logic         sck_b;
  logic         csn;
  logic [11:0]  tx_data;
  logic         tx_valid;
  logic [N-1:0] sd, oe, rdy, und;
  logic [2:0]   lvl [N];

  logic [11:0]  mq [N][$];
  int           ucnt [N];
  int           uexp [N];
  logic [63:0]  bv [N];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_b8
    spi_periph_tx #(
      .DATA_W     (8),
      .FIFO_DEPTH (DEPTH),
      .CPOL       (P_CPOL[g]),
      .CPHA       (P_CPHA[g]),
      .MSB_FIRST  (P_MSB[g]),
      .FILL       (P_FILL[g*8 +: 8])
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .spi_sck_i  (sck_b ^ P_CPOL[g]),
      .spi_csn_i  (csn),
      .spi_sd_o   (sd[g]),
      .spi_oe_o   (oe[g]),
      .tx_data_i  (tx_data[7:0]),
      .tx_valid_i (tx_valid),
      .tx_ready_o (rdy[g]),
      .underrun_o (und[g]),
      .level_o    (lvl[g])
    );
  end

  spi_periph_tx #(
    .DATA_W     (12),
    .FIFO_DEPTH (DEPTH),
    .CPOL       (1'b0),
    .CPHA       (1'b0),
    .MSB_FIRST  (1'b1),
    .FILL       (12'hA5C)
  ) u_dut12 (
    .clk_i      (clk),
    .rst_i      (rst),
    .spi_sck_i  (sck_b),
    .spi_csn_i  (csn),
    .spi_sd_o   (sd[4]),
    .spi_oe_o   (oe[4]),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (rdy[4]),
    .underrun_o (und[4]),
    .level_o    (lvl[4])
  );

  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (und[i] === 1'b1) ucnt[i]++;
  end

  function automatic int wd(input int i);
    return (i == 4) ? 12 : 8;
  endfunction

  function automatic logic [11:0] fill_of(input int i);
    logic [31:0] f;
    f = P_FILL;
    return (i == 4) ? 12'hA5C : {4'h0, f[i*8 +: 8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [11:0] d);
    for (int i = 0; i < N; i++)
      chk($sformatf("ready%0d", i), 32'(rdy[i]),
          32'(mq[i].size() < DEPTH));
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < N; i++)
      if (mq[i].size() < DEPTH)
        mq[i].push_back(d & 12'((1 << wd(i)) - 1));
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < N; i++)
      chk($sformatf("level%0d", i), 32'(lvl[i]), mq[i].size());
  endtask

  // Every load takes the queue head or FILL; bits leave in word order.
  task automatic check_frame(input int k, input bit lp,
                             input logic [11:0] pd);
    for (int i = 0; i < N; i++) begin
      int w, nl, nb;
      bit acc;
      logic [11:0] words [$];
      logic [11:0] cw;
      logic [31:0] got, exp;
      w   = wd(i);
      nl  = 1 + (k - 1) / w;
      acc = mq[i].size() < DEPTH;
      for (int j = 0; j < nl; j++) begin
        if (mq[i].size() > 0) words.push_back(mq[i].pop_front());
        else begin
          words.push_back(fill_of(i));
          uexp[i]++;
        end
        if (j == 0 && lp && acc)
          mq[i].push_back(pd & 12'((1 << w) - 1));
      end
      for (int j = 0; j < nl; j++) begin
        nb  = (k - j * w < w) ? k - j * w : w;
        cw  = words[j];
        got = '0;
        exp = '0;
        for (int p = 0; p < nb; p++) begin
          got = (got << 1) | 32'(bv[i][j*w + p]);
          exp = (exp << 1) | 32'(P_MSB[i] ? cw[w-1-p] : cw[p]);
        end
        chk($sformatf("word%0d_%0d", i, j), got, exp);
      end
      chk($sformatf("underruns%0d", i), ucnt[i], uexp[i]);
      chk($sformatf("level%0d", i), 32'(lvl[i]), mq[i].size());
    end
    chk("oe_idle", 32'(oe), 32'(0));
  endtask

  task automatic frame(input int k, input int half, input bit lp,
                       input logic [11:0] pd);
    for (int i = 0; i < N; i++) bv[i] = '0;
    @(negedge clk);
    csn = 1'b0;
    repeat (3) @(negedge clk);
    if (lp) begin
      tx_data  = pd;
      tx_valid = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("oe_sel", 32'(oe), 32'(5'h1F));
    for (int c = 1; c <= k; c++) begin
      for (int i = 0; i < N; i++)
        if (!P_CPHA[i]) bv[i][c-1] = sd[i];
      sck_b = 1'b1;
      repeat (half) @(negedge clk);
      for (int i = 0; i < N; i++)
        if (P_CPHA[i]) bv[i][c-1] = sd[i];
      sck_b = 1'b0;
      // deselect together with the final return to idle
      if (c == k) csn = 1'b1;
      repeat (half) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check_frame(k, lp, pd);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sd"}, 32'(sd), 32'(0));
    chk({tag, "_oe"}, 32'(oe), 32'(0));
    chk({tag, "_rdy"}, 32'(rdy), 32'(5'h1F));
    chk({tag, "_und"}, 32'(und), 32'(0));
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_lvl%0d", tag, i), 32'(lvl[i]), 32'(0));
  endtask

  initial begin
    rst      = 1'b1;
    sck_b    = 1'b0;
    csn      = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      ucnt[i] = 0;
      uexp[i] = 0;
    end
    repeat (4) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    push(12'h0A5);
    push(12'h03C);
    frame(16, 4, 1'b0, '0);

    push(12'h0C3);
    frame(8, 5, 1'b0, '0);

    // empty FIFO: FILL, then a push on the load cycle stays queued
    frame(8, 4, 1'b1, 12'h077);
    frame(8, 4, 1'b0, '0);

    push(12'h011);
    push(12'h022);
    push(12'h033);
    push(12'h044);
    push(12'h055);
    push(12'h055);
    frame(8, 4, 1'b0, '0);
    push(12'h055);
    frame(32, 4, 1'b0, '0);

    // aborted word is not re-sent
    push(12'h0F0);
    push(12'h00F);
    frame(3, 4, 1'b0, '0);
    frame(8, 4, 1'b0, '0);
    frame(12, 4, 1'b0, '0);

    push(12'($urandom));
    push(12'($urandom));
    push(12'($urandom));
    frame(36, 4, 1'b0, '0);

    for (int r = 0; r < 20; r++) begin
      int np;
      np = $urandom_range(0, 5);
      for (int p = 0; p < np; p++) push(12'($urandom));
      frame($urandom_range(1, 40), $urandom_range(4, 6), 1'b0, '0);
    end

    // reset in the middle of a frame
    push(12'hFFF);
    push(12'($urandom));
    @(negedge clk);
    csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      sck_b = 1'b1;
      repeat (4) @(negedge clk);
      sck_b = 1'b0;
      repeat (4) @(negedge clk);
    end
    sck_b = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++)
      if (mq[i].size() > 0) void'(mq[i].pop_front());
      else uexp[i]++;
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    csn   = 1'b1;
    sck_b = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) mq[i].delete();
    repeat (4) @(negedge clk);
    push(12'($urandom));
    frame(8, 4, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
